// File: rtl/lift_door_ctrl_if.sv
// Door controller signal bundle: request/sensor inputs from the upstream
// request logic and the motor/status outputs back to the motion logic.
interface lift_door_ctrl_if;
  logic       open_req;
  logic       moving;
  logic       obstruct;
  logic       motor_open;
  logic       motor_close;
  logic       door_closed;
  logic [7:0] door_pos;
  logic [1:0] state;

  // Upstream side: drives requests/sensors, observes door status
  modport master (
    output open_req,
    output moving,
    output obstruct,
    input  motor_open,
    input  motor_close,
    input  door_closed,
    input  door_pos,
    input  state
  );

  // Door controller side
  modport slave (
    input  open_req,
    input  moving,
    input  obstruct,
    output motor_open,
    output motor_close,
    output door_closed,
    output door_pos,
    output state
  );
endinterface

// File: rtl/lift_door_ctrl.sv
// Lift door controller: turns a level open request into a timed
// open / hold / close cycle, reversing on obstruction or a fresh request.
// All outputs are Moore, decoded from registered state only.
module lift_door_ctrl #(
  parameter int unsigned TRAVEL = 4,
  parameter int unsigned HOLD   = 6
) (
  input  logic             clk,
  input  logic             rst_n,
  lift_door_ctrl_if.slave  bus
);

  typedef enum logic [1:0] {
    CLOSED  = 2'b00,
    OPENING = 2'b01,
    OPEN    = 2'b10,
    CLOSING = 2'b11
  } state_e;

  localparam logic [7:0] POS_OPEN      = 8'(TRAVEL);
  localparam logic [7:0] POS_LAST_STEP = 8'(TRAVEL - 1);
  localparam logic [7:0] HOLD_LAST     = 8'(HOLD - 1);

  state_e     state_q, state_d;
  logic [7:0] pos_q, pos_d;
  logic [7:0] hold_q, hold_d;

  // Either a new request or an obstruction keeps the door from closing
  logic reopen;
  assign reopen = bus.open_req | bus.obstruct;

  // State, position and dwell registers with asynchronous reset
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= CLOSED;
      pos_q   <= '0;
      hold_q  <= '0;
    end else begin
      state_q <= state_d;
      pos_q   <= pos_d;
      hold_q  <= hold_d;
    end
  end

  // Next-state, position and dwell-count logic
  always_comb begin
    state_d = state_q;
    pos_d   = pos_q;
    hold_d  = hold_q;
    case (state_q)
      CLOSED: begin
        if (bus.open_req && !bus.moving) begin
          state_d = OPENING;
        end
      end
      OPENING: begin
        if (pos_q == POS_LAST_STEP) begin
          pos_d   = POS_OPEN;
          hold_d  = '0;
          state_d = OPEN;
        end else begin
          pos_d = pos_q + 8'd1;
        end
      end
      OPEN: begin
        if (reopen) begin
          hold_d = '0;
        end else if (hold_q == HOLD_LAST) begin
          state_d = CLOSING;
        end else begin
          hold_d = hold_q + 8'd1;
        end
      end
      CLOSING: begin
        // Reversal is checked first so an obstruction on the final step
        // still stops the door from shutting.
        if (reopen) begin
          state_d = OPENING;
        end else if (pos_q == 8'd1) begin
          pos_d   = '0;
          state_d = CLOSED;
        end else begin
          pos_d = pos_q - 8'd1;
        end
      end
      default: begin
        state_d = CLOSED;
        pos_d   = '0;
        hold_d  = '0;
      end
    endcase
  end

  assign bus.motor_open  = (state_q == OPENING);
  assign bus.motor_close = (state_q == CLOSING);
  assign bus.door_closed = (state_q == CLOSED);
  assign bus.door_pos    = pos_q;
  assign bus.state       = state_q;

endmodule

// File: tb/tb_lift_door_ctrl.sv
// Bench for lift_door_ctrl: position/direction model checked every cycle,
// plus directed scenarios with hand-computed literal expectations.
module tb_lift_door_ctrl;

  localparam int TRAVEL = 4;
  localparam int HOLD   = 6;

  logic clk;
  logic rst_n;
  int   checks;
  int   errors;

  lift_door_ctrl_if bus ();

  lift_door_ctrl #(.TRAVEL(TRAVEL), .HOLD(HOLD)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s at %0t: got %0d, expected %0d", name, $time, act, exp);
    end
  endtask

  // Model: door position, travel direction (+1 opening, -1 closing,
  // 0 stationary) and remaining dwell cycles while fully open.
  int m_pos;
  int m_dir;
  int m_dwell;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_pos   <= 0;
      m_dir   <= 0;
      m_dwell <= 0;
    end else if (m_dir == 1) begin
      if (m_pos + 1 == TRAVEL) begin
        m_pos   <= TRAVEL;
        m_dir   <= 0;
        m_dwell <= HOLD;
      end else begin
        m_pos <= m_pos + 1;
      end
    end else if (m_dir == -1) begin
      if (bus.obstruct || bus.open_req) m_dir <= 1;
      else begin
        m_pos <= m_pos - 1;
        if (m_pos == 1) m_dir <= 0;
      end
    end else if (m_pos == 0) begin
      if (bus.open_req && !bus.moving) m_dir <= 1;
    end else begin
      if (bus.obstruct || bus.open_req) m_dwell <= HOLD;
      else begin
        m_dwell <= m_dwell - 1;
        if (m_dwell == 1) m_dir <= -1;
      end
    end
  end

  // Per-cycle comparison against the model
  always @(negedge clk) begin
    int exp_state;
    exp_state = (m_dir == 1)  ? 1 :
                (m_dir == -1) ? 3 :
                (m_pos == 0)  ? 0 : 2;
    chk("model_state",       int'(bus.state),       exp_state);
    chk("model_door_pos",    int'(bus.door_pos),    m_pos);
    chk("model_motor_open",  int'(bus.motor_open),  int'(m_dir == 1));
    chk("model_motor_close", int'(bus.motor_close), int'(m_dir == -1));
    chk("model_door_closed", int'(bus.door_closed), int'(m_dir == 0 && m_pos == 0));
    chk("motors_exclusive",  int'(bus.motor_open & bus.motor_close), 0);
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk_sp(input string name, input int st, input int pos);
    chk({name, "_state"}, int'(bus.state), st);
    chk({name, "_pos"},   int'(bus.door_pos), pos);
  endtask

  initial begin
    checks       = 0;
    errors       = 0;
    rst_n        = 1'b0;
    bus.open_req = 1'b1;
    bus.moving   = 1'b0;
    bus.obstruct = 1'b0;

    // Reset holds the door closed even with a request present
    repeat (3) tick();
    chk_sp("reset", 0, 0);
    chk("reset_closed", int'(bus.door_closed), 1);
    chk("reset_mopen",  int'(bus.motor_open), 0);
    chk("reset_mclose", int'(bus.motor_close), 0);
    bus.open_req = 1'b0;
    rst_n        = 1'b1;
    tick();
    chk_sp("idle", 0, 0);

    // Basic cycle: one-cycle request, full open/hold/close
    bus.open_req = 1'b1;
    for (int e = 1; e <= 15; e++) begin
      tick();
      if (e == 1) bus.open_req = 1'b0;
      case (e)
        1:  chk_sp("basic_e1", 1, 0);
        4:  chk_sp("basic_e4", 1, 3);
        5:  chk_sp("basic_e5", 2, 4);
        10: chk_sp("basic_e10", 2, 4);
        11: chk_sp("basic_e11", 3, 4);
        14: begin
          chk_sp("basic_e14", 3, 1);
          chk("basic_e14_closed", int'(bus.door_closed), 0);
        end
        15: begin
          chk_sp("basic_e15", 0, 0);
          chk("basic_e15_closed", int'(bus.door_closed), 1);
        end
        default: ;
      endcase
    end

    // Hold extension, then obstruction reversal at door_pos 2
    bus.open_req = 1'b1;
    for (int e = 1; e <= 30; e++) begin
      tick();
      if (e == 1)  bus.open_req = 1'b0;
      if (e == 8)  bus.open_req = 1'b1;
      if (e == 9)  bus.open_req = 1'b0;
      if (e == 17) bus.obstruct = 1'b1;
      if (e == 18) bus.obstruct = 1'b0;
      case (e)
        11: chk_sp("hold_e11", 2, 4);
        14: chk_sp("hold_e14", 2, 4);
        15: chk_sp("hold_e15", 3, 4);
        17: chk_sp("rev_e17", 3, 2);
        18: chk_sp("rev_e18", 1, 2);
        19: chk_sp("rev_e19", 1, 3);
        20: chk_sp("rev_e20", 2, 4);
        25: chk_sp("rev_e25", 2, 4);
        26: chk_sp("rev_e26", 3, 4);
        29: chk_sp("rev_e29", 3, 1);
        30: chk_sp("rev_e30", 0, 0);
        default: ;
      endcase
    end

    // Obstruct ignored while opening; obstruct on the last closing step reverses
    bus.open_req = 1'b1;
    for (int e = 1; e <= 28; e++) begin
      tick();
      if (e == 1)  bus.open_req = 1'b0;
      if (e == 2)  bus.obstruct = 1'b1;
      if (e == 3)  bus.obstruct = 1'b0;
      if (e == 14) bus.obstruct = 1'b1;
      if (e == 15) bus.obstruct = 1'b0;
      case (e)
        3:  chk_sp("opn_obs_e3", 1, 2);
        5:  chk_sp("opn_obs_e5", 2, 4);
        14: chk_sp("edge_e14", 3, 1);
        15: begin
          chk_sp("edge_e15", 1, 1);
          chk("edge_e15_closed", int'(bus.door_closed), 0);
        end
        18: chk_sp("edge_e18", 2, 4);
        24: chk_sp("edge_e24", 3, 4);
        28: chk_sp("edge_e28", 0, 0);
        default: ;
      endcase
    end

    // Motion interlock
    bus.moving   = 1'b1;
    bus.open_req = 1'b1;
    for (int i = 0; i < 20; i++) begin
      tick();
      chk("interlock_state", int'(bus.state), 0);
      chk("interlock_mopen", int'(bus.motor_open), 0);
    end
    bus.moving = 1'b0;
    tick();
    chk_sp("interlock_release", 1, 0);
    bus.open_req = 1'b0;
    tick();
    tick();
    chk_sp("pre_async", 1, 2);

    // Async reset between edges
    #3;
    rst_n = 1'b0;
    #1;
    chk_sp("async_rst", 0, 0);
    chk("async_rst_closed", int'(bus.door_closed), 1);
    chk("async_rst_mopen",  int'(bus.motor_open), 0);
    chk("async_rst_mclose", int'(bus.motor_close), 0);
    tick();
    tick();
    rst_n = 1'b1;
    for (int i = 0; i < 5; i++) begin
      tick();
      chk_sp("post_rst_idle", 0, 0);
    end
    bus.open_req = 1'b1;
    tick();
    chk_sp("post_rst_open", 1, 0);
    bus.open_req = 1'b0;
    repeat (19) tick();
    chk_sp("final", 0, 0);

    @(negedge clk);
    #1;
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/lift_door_ctrl.md
# lift_door_ctrl

Sequential door controller for the lift, sitting directly downstream of the combinational door-open request logic. That logic asserts `open_req` when the car is stopped and a floor call is present. This block turns the level request into a timed door cycle: open travel, hold, close travel. It reverses on obstruction or a new request, and reports to the motion logic when the door is fully shut.

## Interface
- `TRAVEL`, default 4: cycles for full door travel, either direction; legal range 1..255.
- `HOLD`, default 6: cycles the door dwells fully open; legal range 1..255.
- `clk` input 1: single clock; all state updates on the rising edge.
- `rst_n` input 1: reset, asynchronous and active-low.
- `open_req` input 1: door-open request level from the upstream request logic.
- `moving` input 1: car in motion; blocks opening from CLOSED.
- `obstruct` input 1: door-edge obstruction sensor, active high.
- `motor_open` output 1: drive door toward open.
- `motor_close` output 1: drive door toward closed.
- `door_closed` output 1: door fully shut; safe to move.
- `door_pos` output 8: door position; 0 = shut, `TRAVEL` = fully open.
- `state` output 2: current FSM state.

## Operation
- States and encodings: CLOSED = 00, OPENING = 01, OPEN = 10, CLOSING = 11.
- Registers: `state`, `door_pos[7:0]`, `hold_cnt[7:0]`. All outputs are Moore, decoded from registers only.
- Output decode:
  - `motor_open` = (state==OPENING).
  - `motor_close` = (state==CLOSING).
  - `door_closed` = (state==CLOSED).
  - `door_pos` and `state` come directly from their registers.
- Reset (async, `rst_n`=0): state=CLOSED, door_pos=0, hold_cnt=0. Output values during reset: `door_closed`=1, `motor_open`=0, `motor_close`=0.
- CLOSED:
  - open_req & !moving -> OPENING, door_pos stays 0.
  - Otherwise remain in CLOSED.
- OPENING:
  - door_pos+1 every cycle.
  - When door_pos==TRAVEL-1: door_pos<=TRAVEL, hold_cnt<=0, -> OPEN.
  - open_req, obstruct and moving are ignored in this state.
- OPEN:
  - If open_req | obstruct: hold_cnt<=0 (dwell restarts); remain in OPEN.
  - Else if hold_cnt==HOLD-1: -> CLOSING.
  - Else hold_cnt+1.
- CLOSING:
  - If obstruct | open_req: -> OPENING, door_pos unchanged (reverses from its current position). This has priority over completion.
  - Else if door_pos==1: door_pos<=0, -> CLOSED.
  - Else door_pos-1.
- Arithmetic: the counters are unsigned 8-bit. door_pos never leaves 0..TRAVEL, and hold_cnt never exceeds HOLD-1, so no wrap is possible for legal parameters.
- `moving` affects only the CLOSED->OPENING transition. Upstream must not assert it while `door_closed`=0; if it does, it is ignored.
- `motor_open` and `motor_close` are never high together.

## Timing
- A request sampled at edge N moves the FSM to OPENING after edge N. `motor_open` rises in cycle N+1.
- OPENING lasts TRAVEL cycles from door_pos=0. The state is OPEN after edge N+TRAVEL.
- OPEN lasts exactly HOLD cycles after the last cycle in which open_req or obstruct was high.
- A full CLOSING phase lasts TRAVEL cycles. `door_closed` rises the cycle after the edge where door_pos goes 1->0.
- Reversal:
  - Obstruct sampled at edge M during CLOSING gives state OPENING after edge M, with door_pos held.
  - Reaching fully open then takes TRAVEL - door_pos cycles.
- Obstruct and door_pos==1 on the same edge: the reversal wins and the door does not close.
- Asserting rst_n=0 mid-cycle forces CLOSED and door_pos=0 immediately, without waiting for a clock edge. Operation resumes on the first edge after release.

## Test plan
- Reset check: hold rst_n=0 with open_req=1 -> state=00, door_closed=1, both motors 0, door_pos=0.
- Basic cycle (TRAVEL=4, HOLD=6): open_req pulsed 1 cycle at edge 1, with moving=0. Required sequence:
  - OPENING for edges 1-4, door_pos 0->4.
  - OPEN for 6 cycles.
  - CLOSING for 4 cycles, door_pos 4->0.
  - CLOSED after edge 15.
- Hold extension: open_req high for 1 cycle at hold_cnt=3 -> hold_cnt returns to 0. OPEN lasts 6 more cycles after the pulse, 10 in total.
- Obstruction reversal: obstruct pulsed while CLOSING at door_pos=2 -> OPENING with door_pos 2, reaching OPEN after 2 cycles. The full hold then repeats before closing again.
- Motion interlock: moving=1 and open_req=1 while CLOSED for 20 cycles -> state stays 00, motor_open stays 0. Dropping moving gives OPENING on the next edge.
- Async reset mid-operation: assert rst_n=0 between edges in OPENING at door_pos=2 -> outputs go to reset values before the next edge. After release, idle in CLOSED until open_req is asserted.
